// File: rtl/forest_pkg.sv
// Shared types and node-word layout for the random-forest tree walkers.
// Node word, MSB..LSB: is_leaf | feat_idx | thresh | left | right | cls.
package forest_pkg;

    localparam int CLASS_W = 2;
    localparam logic [CLASS_W-1:0] CLASS_ERR = 2'd3;
    localparam int FIDX_W = 3;
    localparam int CLS_LSB = 0;
    localparam int RIGHT_LSB = CLASS_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EVAL  = 2'd2,
        DONE  = 2'd3
    } walk_state_t;

    function automatic int node_w(input int feat_w, input int node_aw);
        return 1 + FIDX_W + feat_w + 2 * node_aw + CLASS_W;
    endfunction

    function automatic int left_lsb(input int node_aw);
        return RIGHT_LSB + node_aw;
    endfunction

    function automatic int thresh_lsb(input int node_aw);
        return RIGHT_LSB + 2 * node_aw;
    endfunction

    function automatic int fidx_lsb(input int feat_w, input int node_aw);
        return thresh_lsb(node_aw) + feat_w;
    endfunction

    function automatic int leaf_bit(input int feat_w, input int node_aw);
        return fidx_lsb(feat_w, node_aw) + FIDX_W;
    endfunction

endpackage

// File: rtl/feat_select.sv
// Combinational N_FEAT:1 selector over the latched feature vector.
// Indices at or above N_FEAT return zero; the walker flags them as errors anyway.
module feat_select
    import forest_pkg::*;
#(
    parameter int N_FEAT = 8,
    parameter int FEAT_W = 16
) (
    input  logic [N_FEAT*FEAT_W-1:0] feats,
    input  logic [FIDX_W-1:0]        idx,
    output logic [FEAT_W-1:0]        feat
);

    always_comb begin
        feat = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (int'(idx) == i) begin
                feat = feats[i*FEAT_W +: FEAT_W];
            end
        end
    end

endmodule

// File: rtl/tree_walker.sv
// Walks one decision tree from root to leaf over a 1-cycle-latency node ROM
// and returns the leaf class (CLASS_ERR plus err on a bad feature index or depth overrun).
module tree_walker
    import forest_pkg::*;
#(
    parameter int N_FEAT    = 8,
    parameter int FEAT_W    = 16,
    parameter int NODE_AW   = 6,
    parameter int MAX_DEPTH = 8,
    localparam int NODE_W   = node_w(FEAT_W, NODE_AW)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_FEAT*FEAT_W-1:0] feat_vec,
    output logic [NODE_AW-1:0]       node_addr,
    input  logic [NODE_W-1:0]        node_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLASS_W-1:0]       class_out,
    output logic                     err,
    output logic [1:0]               dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // out_valid, class_out and err stay constant from assertion until that transfer;
    // in_ready is high only in IDLE, and in_valid is ignored everywhere else.

    localparam int DEPTH_W    = $clog2(MAX_DEPTH) + 1;
    localparam int LEAF_BIT   = leaf_bit(FEAT_W, NODE_AW);
    localparam int FIDX_LSB   = fidx_lsb(FEAT_W, NODE_AW);
    localparam int THRESH_LSB = thresh_lsb(NODE_AW);
    localparam int LEFT_LSB   = left_lsb(NODE_AW);
    localparam logic [DEPTH_W-1:0] DEPTH_LIMIT = DEPTH_W'(MAX_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_SAT   = '1;

    walk_state_t               state;
    logic [N_FEAT*FEAT_W-1:0]  feat_q;
    logic [DEPTH_W-1:0]        depth;

    logic                      is_leaf;
    logic [FIDX_W-1:0]         feat_idx;
    logic [FEAT_W-1:0]         thresh;
    logic [NODE_AW-1:0]        left_addr;
    logic [NODE_AW-1:0]        right_addr;
    logic [CLASS_W-1:0]        leaf_cls;
    logic [FEAT_W-1:0]         feat_sel;
    logic                      bad_feat;
    logic                      depth_hit;
    logic                      go_left;

    assign is_leaf    = node_data[LEAF_BIT];
    assign feat_idx   = node_data[FIDX_LSB +: FIDX_W];
    assign thresh     = node_data[THRESH_LSB +: FEAT_W];
    assign left_addr  = node_data[LEFT_LSB +: NODE_AW];
    assign right_addr = node_data[RIGHT_LSB +: NODE_AW];
    assign leaf_cls   = node_data[CLS_LSB +: CLASS_W];

    feat_select #(
        .N_FEAT (N_FEAT),
        .FEAT_W (FEAT_W)
    ) u_feat_select (
        .feats (feat_q),
        .idx   (feat_idx),
        .feat  (feat_sel)
    );

    assign bad_feat  = int'(feat_idx) >= N_FEAT;
    assign depth_hit = depth == DEPTH_LIMIT;
    assign go_left   = feat_sel <= thresh;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            class_out <= '0;
            err       <= 1'b0;
            node_addr <= '0;
            depth     <= '0;
            feat_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        feat_q    <= feat_vec;
                        node_addr <= '0;
                        depth     <= '0;
                        in_ready  <= 1'b0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    state <= EVAL;
                end
                EVAL: begin
                    if (is_leaf) begin
                        class_out <= leaf_cls;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (bad_feat || depth_hit) begin
                        class_out <= CLASS_ERR;
                        err       <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        // Child addresses wrap within NODE_AW; self-loops end at the depth limit.
                        node_addr <= go_left ? left_addr : right_addr;
                        depth     <= (depth == DEPTH_SAT) ? depth : depth + DEPTH_W'(1);
                        state     <= FETCH;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tree_walker.sv
// Self-checking bench for tree_walker: directed tree scenarios plus random trees,
// scored against a behavioural tree-walk model and a 1-cycle-latency ROM model.
module tb_tree_walker;
    import forest_pkg::*;

    localparam int N_FEAT    = 6;
    localparam int FEAT_W    = 16;
    localparam int NODE_AW   = 6;
    localparam int MAX_DEPTH = 8;
    localparam int NODE_W    = 1 + 3 + FEAT_W + 2 * NODE_AW + 2;
    localparam int N_NODES   = 1 << NODE_AW;
    localparam int FV_W      = N_FEAT * FEAT_W;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [FV_W-1:0]   feat_vec;
    logic [NODE_AW-1:0] node_addr;
    logic [NODE_W-1:0] node_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        class_out;
    logic              err;
    logic [1:0]        dbg_state;

    logic [NODE_W-1:0] rom [N_NODES];
    logic [2:0]        exp_q[$];

    int checks = 0;
    int errors = 0;
    int m_cls, m_err, m_d;
    int m_path[$];
    int obs_cls, obs_err, obs_lat;

    tree_walker #(
        .N_FEAT    (N_FEAT),
        .FEAT_W    (FEAT_W),
        .NODE_AW   (NODE_AW),
        .MAX_DEPTH (MAX_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .feat_vec  (feat_vec),
        .node_addr (node_addr),
        .node_data (node_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .class_out (class_out),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // clock / reset block and ROM model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) node_data <= rom[node_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NODE_W-1:0] make_node(input bit leaf, input int fidx, input int thr,
                                                     input int left, input int right, input int cls);
        return {leaf, 3'(fidx), FEAT_W'(thr), NODE_AW'(left), NODE_AW'(right), 2'(cls)};
    endfunction

    function automatic void fill_leaves(input int cls);
        for (int n = 0; n < N_NODES; n++) rom[n] = make_node(1'b1, 0, 0, 0, 0, cls);
    endfunction

    // reference model: walk the tree with plain arithmetic on the node fields
    function automatic void model(input logic [FV_W-1:0] fv);
        int addr;
        logic [NODE_W-1:0] node;
        int fidx, thr;
        addr = 0;
        m_d = 0;
        m_path.delete();
        m_path.push_back(0);
        while (1) begin
            node = rom[addr];
            fidx = int'(node[NODE_W-2 -: 3]);
            thr  = int'(node[NODE_W-5 -: FEAT_W]);
            if (node[NODE_W-1]) begin
                m_cls = int'(node[1:0]);
                m_err = 0;
                break;
            end
            if (fidx >= N_FEAT || m_d == MAX_DEPTH) begin
                m_cls = 3;
                m_err = 1;
                break;
            end
            if (int'(fv[fidx*FEAT_W +: FEAT_W]) <= thr) addr = int'(node[2+2*NODE_AW-1 -: NODE_AW]);
            else                                        addr = int'(node[2+NODE_AW-1 -: NODE_AW]);
            m_d++;
            m_path.push_back(addr);
        end
    endfunction

    function automatic logic [FV_W-1:0] rand_vec(input int max_val);
        logic [FV_W-1:0] v;
        for (int i = 0; i < N_FEAT; i++) v[i*FEAT_W +: FEAT_W] = FEAT_W'($urandom_range(0, max_val));
        return v;
    endfunction

    // driver: present one sample, follow the walk, hold DONE for 'hold' cycles, then take the result
    task automatic run_sample(input logic [FV_W-1:0] fv, input int hold);
        logic [2:0] exp;
        int m;
        model(fv);
        exp_q.push_back({m_err[0], m_cls[1:0]});
        @(negedge clk);
        m = 0;
        while (!in_ready && m < 50) begin
            @(negedge clk);
            m++;
        end
        check("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        feat_vec  = fv;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'($urandom_range(0, 1));
        feat_vec = rand_vec(65535);
        m = 0;
        while (m < 100) begin
            @(negedge clk);
            if (out_valid) break;
            if (m / 2 < m_path.size()) check("node_addr", node_addr, m_path[m/2]);
            check("busy_in_ready", in_ready, 0);
            in_valid = 1'($urandom_range(0, 1));
            feat_vec = rand_vec(65535);
            m++;
        end
        obs_lat = m + 1;
        obs_cls = int'(class_out);
        obs_err = int'(err);
        check("latency", obs_lat, 3 + 2 * m_d);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", out_valid, 1);
            check("hold_class", {err, class_out}, exp_q[0]);
            check("hold_in_ready", in_ready, 0);
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        exp = exp_q.pop_front();
        check("result", {out_valid, err, class_out}, {1'b1, exp});
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_xfer", {out_valid, in_ready}, 2'b01);
        out_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check(tag, {in_ready, out_valid, class_out, err, node_addr, dbg_state},
              {1'b1, 1'b0, 2'd0, 1'b0, NODE_AW'(0), IDLE});
    endtask

    task automatic load_depth2_tree();
        fill_leaves(0);
        rom[0] = make_node(1'b0, 3, 100, 1, 2, 0);
        rom[1] = make_node(1'b0, 0, 4, 3, 4, 0);
        rom[2] = make_node(1'b1, 0, 0, 0, 0, 2);
        rom[3] = make_node(1'b1, 0, 0, 0, 0, 0);
        rom[4] = make_node(1'b1, 0, 0, 0, 0, 1);
    endtask

    initial begin
        logic [FV_W-1:0] fv;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        feat_vec = '0;
        fill_leaves(0);
        repeat (2) @(negedge clk);
        check_reset_values("reset_state");
        rst = 1'b0;

        // root is a leaf
        rom[0] = make_node(1'b1, 0, 0, 0, 0, 2);
        run_sample(rand_vec(65535), 0);
        check("t1_class", {obs_err[0], obs_cls[1:0]}, 3'b010);
        check("t1_latency", obs_lat, 3);

        // depth-2 tree, left then right; then root right branch
        load_depth2_tree();
        fv = rand_vec(65535);
        fv[3*FEAT_W +: FEAT_W] = 16'd100;
        fv[0 +: FEAT_W] = 16'd5;
        run_sample(fv, 1);
        check("t2_class", {obs_err[0], obs_cls[1:0]}, 3'b001);
        check("t2_latency", obs_lat, 7);
        fv[3*FEAT_W +: FEAT_W] = 16'd101;
        run_sample(fv, 0);
        check("t2b_class", {obs_err[0], obs_cls[1:0]}, 3'b010);
        check("t2b_latency", obs_lat, 5);

        // self-loop at root hits the depth limit
        fill_leaves(0);
        rom[0] = make_node(1'b0, 0, 65535, 0, 0, 0);
        run_sample(rand_vec(65535), 0);
        check("t3_class", {obs_err[0], obs_cls[1:0]}, 3'b111);
        check("t3_latency", obs_lat, 19);

        // feature index out of range
        rom[0] = make_node(1'b0, 7, 0, 1, 2, 0);
        run_sample(rand_vec(65535), 0);
        check("t4_class", {obs_err[0], obs_cls[1:0]}, 3'b111);
        check("t4_latency", obs_lat, 3);

        // backpressure in DONE for 10 cycles
        load_depth2_tree();
        fv[3*FEAT_W +: FEAT_W] = 16'd7;
        fv[0 +: FEAT_W] = 16'd4;
        run_sample(fv, 10);
        check("t5_class", {obs_err[0], obs_cls[1:0]}, 3'b000);

        // reset in the middle of a deep walk
        fill_leaves(0);
        rom[0] = make_node(1'b0, 1, 65535, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b1;
        feat_vec = rand_vec(65535);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("t6_in_eval", dbg_state, EVAL);
        rst = 1'b1;
        #1;
        check_reset_values("t6_async_reset");
        @(negedge clk);
        check_reset_values("t6_reset_next");
        rst = 1'b0;
        load_depth2_tree();
        fv[3*FEAT_W +: FEAT_W] = 16'd50;
        fv[0 +: FEAT_W] = 16'd9;
        run_sample(fv, 0);
        check("t6_after", {obs_err[0], obs_cls[1:0]}, 3'b001);

        // random trees, small value range so threshold ties occur often
        for (int r = 0; r < 30; r++) begin
            for (int n = 0; n < N_NODES; n++) begin
                rom[n] = make_node($urandom_range(0, 99) < 35,
                                   ($urandom_range(0, 99) < 8) ? $urandom_range(6, 7) : $urandom_range(0, 5),
                                   $urandom_range(0, 15), $urandom_range(0, N_NODES - 1),
                                   $urandom_range(0, N_NODES - 1), $urandom_range(0, 3));
            end
            for (int s = 0; s < 4; s++) run_sample(rand_vec(15), $urandom_range(0, 3));
        end

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
